// File: rtl/nibbler_pkg.sv
// nibbler_pkg -- shared definitions for the nibbler 4-bit accumulator core.
//   OPC_W    : width of the opcode field at the top of an instruction word
//   PORT_W   : width of the I/O port index taken from the low argument bits
//   opcode_e : the sixteen instruction opcodes
//   state_e  : control FSM states
package nibbler_pkg;

    localparam int OPC_W  = 4;
    localparam int PORT_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LIT   = 4'h1,
        OP_ADDI  = 4'h2,
        OP_NANDI = 4'h3,
        OP_CMPI  = 4'h4,
        OP_LD    = 4'h5,
        OP_ST    = 4'h6,
        OP_ADDM  = 4'h7,
        OP_IN    = 4'h8,
        OP_OUT   = 4'h9,
        OP_JMP   = 4'hA,
        OP_JC    = 4'hB,
        OP_JNZ   = 4'hC,
        OP_CALL  = 4'hD,
        OP_RET   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_OUT_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

endpackage

// File: rtl/nibbler_stack.sv
// nibbler_stack -- LIFO return-address stack for CALL/RET.
//   clk, rst_n : clock, asynchronous active-low reset (clears the pointer)
//   push, pop  : one-cycle requests; ignored when full / empty respectively
//   push_data  : return address to store
//   top_data   : most recently pushed address (0 when empty)
//   full,empty : occupancy status derived from the registered pointer
module nibbler_stack
    import nibbler_pkg::*;
#(
    parameter int STACK_D = 4,
    parameter int W       = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int SP_W = $clog2(STACK_D + 1);

    logic [SP_W-1:0] sp_r;
    logic [W-1:0]    mem_r [STACK_D];

    assign full  = (sp_r == SP_W'(STACK_D));
    assign empty = (sp_r == {SP_W{1'b0}});

    // Stack pointer: counts stored entries, guarded against over/underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {SP_W{1'b0}};
        end else if (push && !full) begin
            sp_r <= sp_r + SP_W'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - SP_W'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage: the slot at the current pointer receives a push.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STACK_D; k++) begin
            if (push && !full && (sp_r == SP_W'(k))) begin
                mem_r[k] <= push_data;
            end else begin
                mem_r[k] <= mem_r[k];
            end
        end
    end

    // Top-of-stack read: entry just below the pointer, compared per slot so
    // the index never needs to be narrowed.
    always_comb begin
        top_data = {W{1'b0}};
        for (int k = 0; k < STACK_D; k++) begin
            top_data = (sp_r == SP_W'(k + 1)) ? mem_r[k] : top_data;
        end
    end

endmodule

// File: rtl/nibbler_core.sv
// nibbler_core -- small accumulator CPU: FETCH/EXEC control, one accumulator
// with carry/zero flags, data memory port, NUM_IN input ports, NUM_OUT
// valid/ready output registers and a STACK_D-deep return stack.
//   clk, reset          : clock, asynchronous active-low reset
//   imem_addr/imem_data : program port (address = PC, combinational read)
//   dmem_*              : data port (address = IR arg, data = A, 1-cycle strobe)
//   in_data             : input ports, port k at [k*DATA_W +: DATA_W]
//   out_data/out_valid/out_ready : output registers with per-port handshake
//   acc, c_flag, z_flag : architectural state
//   halted, err         : core stopped / sticky stack fault
module nibbler_core
    import nibbler_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 12,
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 3,
    parameter int STACK_D = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [OPC_W+ADDR_W-1:0]   imem_data,
    output logic [ADDR_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wdata,
    output logic                      dmem_we,
    input  logic [DATA_W-1:0]         dmem_rdata,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [DATA_W-1:0]         acc,
    output logic                      c_flag,
    output logic                      z_flag,
    output logic                      halted,
    output logic                      err
);

    state_e                    state_r, state_nxt_s;
    logic [ADDR_W-1:0]         pc_r, pc_nxt_s;
    logic [OPC_W+ADDR_W-1:0]   ir_r, ir_nxt_s;
    logic [DATA_W-1:0]         acc_r, acc_nxt_s;
    logic                      c_r, c_nxt_s;
    logic                      z_r, z_nxt_s;
    logic                      err_r, err_nxt_s;
    logic [NUM_OUT*DATA_W-1:0] out_data_r, out_data_nxt_s;
    logic [NUM_OUT-1:0]        out_valid_r, out_valid_nxt_s;

    opcode_e                   op_s;
    logic [ADDR_W-1:0]         arg_s;
    logic [DATA_W-1:0]         imm_s;
    logic [PORT_W-1:0]         port_s;
    logic [DATA_W-1:0]         add_opnd_s;
    logic [DATA_W:0]           sum_s;
    logic [DATA_W-1:0]         nand_s;
    logic [DATA_W-1:0]         in_sel_s;
    logic                      out_ok_s;
    logic                      ready_sel_s;

    logic                      push_s, pop_s;
    logic                      stk_full_s, stk_empty_s;
    logic [ADDR_W-1:0]         stk_top_s;

    // Instruction field decode from the latched IR.
    assign op_s       = opcode_e'(ir_r[ADDR_W +: OPC_W]);
    assign arg_s      = ir_r[ADDR_W-1:0];
    assign imm_s      = arg_s[DATA_W-1:0];
    assign port_s     = arg_s[PORT_W-1:0];

    // ADDI and ADDM share one adder; the extra top bit is the carry out.
    assign add_opnd_s = (op_s == OP_ADDM) ? dmem_rdata : imm_s;
    assign sum_s      = {1'b0, acc_r} + {1'b0, add_opnd_s};
    assign nand_s     = ~(acc_r & imm_s);

    // Port selection: out-of-range indices read 0 and are never "ok"/"ready".
    always_comb begin
        in_sel_s    = {DATA_W{1'b0}};
        out_ok_s    = 1'b0;
        ready_sel_s = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_sel_s = (port_s == PORT_W'(k)) ? in_data[k*DATA_W +: DATA_W] : in_sel_s;
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            out_ok_s    = (port_s == PORT_W'(k)) ? 1'b1         : out_ok_s;
            ready_sel_s = (port_s == PORT_W'(k)) ? out_ready[k] : ready_sel_s;
        end
    end

    // Next-state and datapath update for every FSM state.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        ir_nxt_s        = ir_r;
        acc_nxt_s       = acc_r;
        c_nxt_s         = c_r;
        z_nxt_s         = z_r;
        err_nxt_s       = err_r;
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = out_valid_r;
        push_s          = 1'b0;
        pop_s           = 1'b0;

        case (state_r)
            ST_FETCH: begin
                ir_nxt_s    = imem_data;
                pc_nxt_s    = pc_r + ADDR_W'(1);
                state_nxt_s = ST_EXEC;
            end

            ST_EXEC: begin
                state_nxt_s = ST_FETCH;
                case (op_s)
                    OP_NOP: begin
                    end
                    OP_LIT: begin
                        acc_nxt_s = imm_s;
                    end
                    OP_ADDI, OP_ADDM: begin
                        acc_nxt_s = sum_s[DATA_W-1:0];
                        c_nxt_s   = sum_s[DATA_W];
                        z_nxt_s   = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
                    end
                    OP_NANDI: begin
                        acc_nxt_s = nand_s;
                        c_nxt_s   = 1'b0;
                        z_nxt_s   = (nand_s == {DATA_W{1'b0}});
                    end
                    OP_CMPI: begin
                        c_nxt_s = (acc_r >= imm_s);
                        z_nxt_s = (acc_r == imm_s);
                    end
                    OP_LD: begin
                        acc_nxt_s = dmem_rdata;
                    end
                    OP_ST: begin
                        // The write strobe is decoded directly from state/IR.
                    end
                    OP_IN: begin
                        acc_nxt_s = in_sel_s;
                    end
                    OP_OUT: begin
                        if (out_ok_s) begin
                            for (int k = 0; k < NUM_OUT; k++) begin
                                out_data_nxt_s[k*DATA_W +: DATA_W] = (port_s == PORT_W'(k)) ?
                                    acc_r : out_data_r[k*DATA_W +: DATA_W];
                                out_valid_nxt_s[k] = (port_s == PORT_W'(k));
                            end
                            state_nxt_s = ST_OUT_WAIT;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end
                    OP_JMP: begin
                        pc_nxt_s = arg_s;
                    end
                    OP_JC: begin
                        pc_nxt_s = c_r ? arg_s : pc_r;
                    end
                    OP_JNZ: begin
                        pc_nxt_s = (!z_r) ? arg_s : pc_r;
                    end
                    OP_CALL: begin
                        // pc_r was already advanced in FETCH: it is the return address.
                        if (stk_full_s) begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ST_HALT;
                        end else begin
                            push_s   = 1'b1;
                            pc_nxt_s = arg_s;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty_s) begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ST_HALT;
                        end else begin
                            pop_s    = 1'b1;
                            pc_nxt_s = stk_top_s;
                        end
                    end
                    OP_HALT: begin
                        state_nxt_s = ST_HALT;
                    end
                    default: begin
                        state_nxt_s = ST_FETCH;
                    end
                endcase
            end

            ST_OUT_WAIT: begin
                // Only one port can be valid at a time, so clearing all is exact.
                if (ready_sel_s) begin
                    out_valid_nxt_s = {NUM_OUT{1'b0}};
                    state_nxt_s     = ST_FETCH;
                end else begin
                    state_nxt_s     = ST_OUT_WAIT;
                end
            end

            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end

            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Architectural registers: PC, IR, accumulator, flags, outputs, error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= {ADDR_W{1'b0}};
            ir_r        <= {(OPC_W+ADDR_W){1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            c_r         <= 1'b0;
            z_r         <= 1'b0;
            err_r       <= 1'b0;
            out_data_r  <= {(NUM_OUT*DATA_W){1'b0}};
            out_valid_r <= {NUM_OUT{1'b0}};
        end else begin
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            acc_r       <= acc_nxt_s;
            c_r         <= c_nxt_s;
            z_r         <= z_nxt_s;
            err_r       <= err_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    nibbler_stack #(
        .STACK_D (STACK_D),
        .W       (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_r),
        .top_data  (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // The strobe is a pure decode of registered state, so an asynchronous
    // reset drops it at once and no write edge can follow.
    assign dmem_we    = (state_r == ST_EXEC) && (op_s == OP_ST);
    assign imem_addr  = pc_r;
    assign dmem_addr  = arg_s;
    assign dmem_wdata = acc_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign acc        = acc_r;
    assign c_flag     = c_r;
    assign z_flag     = z_r;
    assign err        = err_r;
    assign halted     = (state_r == ST_HALT);

endmodule

// File: tb/tb_nibbler_core.sv
// Testbench for nibbler_core: directed scenarios for timing/boundary cases,
// then random programs run on an instruction-level reference model whose
// stores and output transfers are queued and matched by a monitor.
module tb_nibbler_core;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 12;
    localparam int NUM_IN  = 3;
    localparam int NUM_OUT = 3;
    localparam int STACK_D = 4;

    typedef struct packed {
        logic        kind;   // 0 = store, 1 = output transfer
        logic [11:0] addr;   // data address or port number
        logic [3:0]  data;
    } ev_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [ADDR_W-1:0]         imem_addr;
    logic [4+ADDR_W-1:0]       imem_data;
    logic [ADDR_W-1:0]         dmem_addr;
    logic [DATA_W-1:0]         dmem_wdata;
    logic                      dmem_we;
    logic [DATA_W-1:0]         dmem_rdata;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [DATA_W-1:0]         acc;
    logic                      c_flag, z_flag, halted, err;

    logic [15:0] prog   [4096];
    logic [3:0]  dmem   [4096];
    logic [3:0]  dm_init[16];
    logic [3:0]  ref_dm [16];
    logic [3:0]  in_val [3];
    logic [3:0]  m_out  [3];
    ev_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    int          m_pc, m_acc;
    bit          m_c, m_z, m_err;

    always #5 clk = ~clk;

    assign imem_data  = prog[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign in_data    = {in_val[2], in_val[1], in_val[0]};

    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    nibbler_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_IN(NUM_IN),
        .NUM_OUT(NUM_OUT), .STACK_D(STACK_D)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .c_flag(c_flag), .z_flag(z_flag),
        .halted(halted), .err(err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input ev_t got);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_unexpected: got 0x%0h, required no event", nm, got);
        end else begin
            e = sb.pop_front();
            check(nm, 32'(got), 32'(e));
        end
    endtask

    // Monitor: a store or output handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (dmem_we) sb_check("store", {1'b0, dmem_addr, dmem_wdata});
            for (int p = 0; p < NUM_OUT; p++) begin
                if (out_valid[p] && out_ready[p])
                    sb_check("out", {1'b1, 12'(p), out_data[p*DATA_W +: DATA_W]});
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 16'hF000;
    endtask

    task automatic assert_rst();
        reset     = 1'b0;
        out_ready = 3'b000;
        repeat (2) @(posedge clk);
        clear_prog();
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int max_cyc, input string nm);
        int cyc = 0;
        while (!halted && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            out_ready = 3'($urandom);
            cyc++;
        end
        if (!halted) check({nm, "_timeout"}, 32'(halted), 32'd1);
    endtask

    // Instruction-level reference: executes whole instructions in order.
    task automatic ref_run(output bit done);
        int pc, a, s;
        bit c, z;
        logic [15:0] w;
        logic [3:0]  op, lo;
        logic [11:0] arg;
        int stk[$];
        pc = 0; a = 0; c = 0; z = 0; m_err = 0; done = 0;
        for (int i = 0; i < 3; i++) m_out[i] = 4'h0;
        for (int step = 0; step < 300 && !done; step++) begin
            w = prog[pc]; op = w[15:12]; arg = w[11:0]; lo = w[3:0];
            pc = (pc + 1) % 4096;
            case (op)
                4'h1: a = lo;
                4'h2: begin s = a + lo; c = (s > 15); a = s % 16; z = (a == 0); end
                4'h3: begin a = 15 - (a & lo); c = 0; z = (a == 0); end
                4'h4: begin c = (a >= lo); z = (a == lo); end
                4'h5: a = ref_dm[arg[3:0]];
                4'h6: begin ref_dm[arg[3:0]] = 4'(a); sb.push_back({1'b0, arg, 4'(a)}); end
                4'h7: begin s = a + ref_dm[arg[3:0]]; c = (s > 15); a = s % 16; z = (a == 0); end
                4'h8: begin if (lo < 3) a = in_val[lo]; else a = 0; end
                4'h9: begin
                    if (lo < 3) begin
                        m_out[lo] = 4'(a);
                        sb.push_back({1'b1, 12'(lo), 4'(a)});
                    end
                end
                4'hA: pc = arg;
                4'hB: if (c) pc = arg;
                4'hC: if (!z) pc = arg;
                4'hD: begin
                    if (stk.size() == STACK_D) begin m_err = 1; done = 1; end
                    else begin stk.push_back(pc); pc = arg; end
                end
                4'hE: begin
                    if (stk.size() == 0) begin m_err = 1; done = 1; end
                    else pc = stk.pop_back();
                end
                4'hF: done = 1;
                default: ;
            endcase
        end
        m_pc = pc; m_acc = a; m_c = c; m_z = z;
    endtask

    task automatic gen_prog();
        logic [3:0]  op;
        logic [11:0] arg;
        for (int i = 0; i < 23; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
            case (op)
                4'h5, 4'h6, 4'h7:        arg = 12'($urandom_range(0, 15));
                4'h8, 4'h9:              arg = {8'($urandom), 4'($urandom_range(0, 4))};
                4'hA, 4'hB, 4'hC, 4'hD:  arg = 12'($urandom_range(i + 1, 23));
                default:                 arg = 12'($urandom);
            endcase
            prog[i] = {op, arg};
        end
        prog[23] = 16'hF000;
    endtask

    initial begin
        bit done;
        reset = 1'b0;
        out_ready = 3'b000;
        for (int i = 0; i < 3; i++) in_val[i] = 4'(i + 1);
        clear_prog();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",    32'(imem_addr), 32'd0);
        check("rst_acc",   32'(acc), 32'd0);
        check("rst_flags", 32'({c_flag, z_flag, halted, err}), 32'd0);
        check("rst_out",   32'({out_valid, out_data}), 32'd0);
        check("rst_we",    32'(dmem_we), 32'd0);

        // LIT 9; ADDI 8
        prog[0] = 16'h1009; prog[1] = 16'h2008;
        release_rst();
        repeat (2) @(posedge clk); #1;
        check("lit_acc", 32'(acc), 32'd9);
        repeat (2) @(posedge clk); #1;
        check("addi_acc", 32'(acc), 32'd1);
        check("addi_cz", 32'({c_flag, z_flag}), 32'b10);

        // LIT 5; CMPI 5; JNZ 0x020 (not taken)
        assert_rst();
        prog[0] = 16'h1005; prog[1] = 16'h4005; prog[2] = 16'hC020;
        release_rst();
        repeat (6) @(posedge clk); #1;
        check("jnz_acc", 32'(acc), 32'd5);
        check("jnz_cz", 32'({c_flag, z_flag}), 32'b11);
        check("jnz_pc", 32'(imem_addr), 32'd3);

        // LIT 7; OUT 1 with ready held low, then raised
        assert_rst();
        prog[0] = 16'h1007; prog[1] = 16'h9001;
        release_rst();
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("outw_valid", 32'(out_valid), 32'b010);
            check("outw_data", 32'(out_data[7:4]), 32'd7);
        end
        @(posedge clk); #1;
        out_ready = 3'b010;
        @(posedge clk); #1;
        check("out_clr_valid", 32'(out_valid), 32'd0);
        check("out_keep_data", 32'(out_data[7:4]), 32'd7);
        check("out_next_pc", 32'(imem_addr), 32'd2);

        // Five nested CALLs overflow a 4-deep stack
        assert_rst();
        prog[12'h000] = 16'hD010; prog[12'h010] = 16'hD020; prog[12'h020] = 16'hD030;
        prog[12'h030] = 16'hD040; prog[12'h040] = 16'hD050;
        release_rst();
        wait_halt(50, "call_ovf");
        repeat (3) @(posedge clk); #1;
        check("call_ovf_eh", 32'({err, halted}), 32'b11);
        check("call_ovf_pc", 32'(imem_addr), 32'h041);

        // RET on an empty stack
        assert_rst();
        prog[0] = 16'hE000;
        release_rst();
        wait_halt(20, "ret_udf");
        #1;
        check("ret_udf_eh", 32'({err, halted}), 32'b11);
        check("ret_udf_pc", 32'(imem_addr), 32'd1);

        // Reset asserted during the EXEC of ST
        assert_rst();
        dmem[5] <= 4'hA;
        prog[0] = 16'h1003; prog[1] = 16'h6005;
        release_rst();
        repeat (3) @(posedge clk); #1;
        check("st_we_exec", 32'(dmem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("st_abort_we", 32'(dmem_we), 32'd0);
        check("st_abort_state", 32'({imem_addr, acc, c_flag, z_flag, halted, err}), 32'd0);
        repeat (2) @(posedge clk); #1;
        check("st_abort_mem", 32'(dmem[5]), 32'hA);
        check("st_abort_out", 32'({out_valid, out_data, dmem_we}), 32'd0);

        // Random programs against the reference model
        mon_en = 1'b1;
        for (int t = 0; t < 25; t++) begin
            assert_rst();
            for (int i = 0; i < 3; i++) in_val[i] = 4'($urandom);
            for (int i = 0; i < 16; i++) dm_init[i] = 4'($urandom);
            done = 1'b0;
            while (!done) begin
                gen_prog();
                sb.delete();
                for (int i = 0; i < 16; i++) ref_dm[i] = dm_init[i];
                ref_run(done);
            end
            for (int i = 0; i < 16; i++) dmem[i] <= dm_init[i];
            release_rst();
            wait_halt(4000, "rand");
            repeat (2) @(posedge clk); #1;
            check("rand_drain", 32'(sb.size()), 32'd0);
            check("rand_acc", 32'(acc), 32'(m_acc));
            check("rand_cz", 32'({c_flag, z_flag}), 32'({m_c, m_z}));
            check("rand_eh", 32'({err, halted}), 32'({m_err, 1'b1}));
            check("rand_pc", 32'(imem_addr), 32'(m_pc));
            check("rand_outdata", 32'(out_data), 32'({m_out[2], m_out[1], m_out[0]}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nibbler_core.md
NIBBLER_CORE -- requirements
Module: nibbler_core

Interface
REQ-001 Parameters SHALL be: DATA_W (4, accumulator/data width); ADDR_W (12, program/data address width, >= DATA_W); NUM_IN (3, input ports, 1..16); NUM_OUT (3, output ports, 1..16); STACK_D (4, return-stack depth, >= 1).
REQ-002 Ports SHALL be, one per line, name direction width meaning:
  clk  in  1  single clock, rising edge;
  reset  in  1  asynchronous, active-low reset;
  imem_addr  out  ADDR_W  program address (=PC);
  imem_data  in  4+ADDR_W  instruction word, same-cycle combinational read;
  dmem_addr  out  ADDR_W  data address (=IR[ADDR_W-1:0]);
  dmem_wdata  out  DATA_W  store data (=A);
  dmem_we  out  1  one-cycle write strobe;
  dmem_rdata  in  DATA_W  combinational read data;
  in_data  in  NUM_IN*DATA_W  input ports, port k at bits [k*DATA_W +: DATA_W];
  out_data  out  NUM_OUT*DATA_W  output registers, same packing;
  out_valid  out  NUM_OUT  per-port valid;
  out_ready  in  NUM_OUT  per-port ready;
  acc  out  DATA_W  accumulator A;
  c_flag, z_flag  out  1  carry, zero flags;
  halted  out  1  core in HALT;
  err  out  1  sticky stack-fault flag.

Function
REQ-003 Instruction word SHALL be {op[3:0], arg[ADDR_W-1:0]}; imm = arg[DATA_W-1:0]; port index = arg[3:0].
REQ-004 Opcodes SHALL be: 0 NOP, 1 LIT A=imm, 2 ADDI, 3 NANDI, 4 CMPI, 5 LD A=mem[arg], 6 ST mem[arg]=A, 7 ADDM, 8 IN, 9 OUT, A JMP, B JC, C JNZ, D CALL, E RET, F HALT.
REQ-005 FSM states SHALL be FETCH, EXEC, OUT_WAIT, HALT; FETCH->EXEC always; EXEC->FETCH except OUT (->OUT_WAIT), HALT or stack fault (->HALT); HALT is absorbing until reset.
REQ-006 In FETCH the core SHALL latch imem_data into IR and set PC=PC+1, wrapping modulo 2^ADDR_W.
REQ-007 Every non-OUT instruction SHALL take exactly 2 cycles; its results become visible on the clock edge ending EXEC.
REQ-008 ADDI/ADDM SHALL compute {C,A}=A+operand (DATA_W+1 bits) and set Z=(A_new==0).
REQ-009 NANDI SHALL set A=~(A&imm) and Z=(A_new==0), with C cleared.
REQ-010 CMPI SHALL leave A unchanged and set C=(A>=imm) and Z=(A==imm).
REQ-011 LIT, LD and IN SHALL leave both flags unchanged.
REQ-012 IN from a port index >= NUM_IN SHALL load 0.
REQ-013 ST SHALL assert dmem_we for exactly the EXEC cycle; dmem_we SHALL be 0 at all other times.
REQ-014 JMP SHALL set PC=arg; JC SHALL do so only if C=1; JNZ SHALL do so only if Z=0; flags are unchanged.
REQ-015 CALL SHALL push the already-incremented PC and set PC=arg.
REQ-016 RET SHALL pop into PC.
REQ-017 CALL with STACK_D entries, or RET with an empty stack, SHALL leave PC and the stack unchanged, set err and enter HALT.
REQ-018 OUT to port p < NUM_OUT SHALL load A into out_data[p] and set out_valid[p], then wait in OUT_WAIT.
REQ-019 out_valid[p] SHALL remain 1 with data stable until out_ready[p]=1 on a clock edge; on that edge valid clears and the FSM goes to FETCH. If ready is already high, OUT takes exactly 3 cycles.
REQ-020 OUT to a port index >= NUM_OUT SHALL be a 2-cycle NOP.
REQ-021 out_data SHALL keep the last written value after the handshake.
REQ-022 HALT SHALL freeze PC, A, flags and outputs; halted=1.

Reset
REQ-023 While reset=0 the core SHALL hold: state=FETCH, PC=0, IR=0, A=0, C=0, Z=0, stack pointer=0, out_data=0, out_valid=0, err=0, halted=0, dmem_we=0.
REQ-024 Assertion mid-instruction, including in OUT_WAIT, SHALL abort it immediately with no memory write and no further handshake.
REQ-025 Release SHALL begin with FETCH of address 0.

Structure
REQ-026 Package nibbler_pkg SHALL hold the opcode enum, the FSM state enum and the opcode-field width constant.
REQ-027 The return stack SHALL be a separate sub-module nibbler_stack (push, pop, full, empty, parameter STACK_D).

Verification
REQ-028 LIT 9; ADDI 8 (DATA_W=4) SHALL yield A=1, C=1, Z=0, with 4 cycles from the end of reset.
REQ-029 LIT 5; CMPI 5; JNZ 0x020 SHALL not branch (Z=1, C=1, A=5), and the next fetch is at address 3.
REQ-030 LIT 7; OUT 1 with out_ready[1] low for 5 cycles SHALL hold out_valid[1]=1 and out_data[1]=7 throughout, and valid SHALL clear on the edge where ready rises.
REQ-031 Five nested CALLs with STACK_D=4 SHALL set err=1 and halted=1 with PC equal to the fifth CALL's address+1.
REQ-032 RET with an empty stack SHALL set err=1 and halted=1.
REQ-033 Reset asserted during the EXEC of ST SHALL produce no dmem_we pulse and all outputs at their REQ-023 values.
